// File: rtl/hud_pkg.sv
// hud_pkg: colour constants (RRRGGGBB) shared by the HUD, sprite and background renderers.
package hud_pkg;
    localparam logic [7:0] HUD_RED   = 8'b111_000_00;
    localparam logic [7:0] HUD_BLACK = 8'b000_000_00;
    localparam logic [7:0] HUD_WHITE = 8'b111_111_11;
    typedef enum logic {P1 = 1'b0, P2 = 1'b1} player_e;
endpackage

// File: rtl/hud_bar_renderer_if.sv
// hud_bar_renderer_if: pixel coordinates and levels in, registered colour and active flag out.
interface hud_bar_renderer_if #(parameter int N_ICONS = 3);
    logic [9:0]         x;
    logic [9:0]         y;
    logic [N_ICONS-1:0] p1_level;
    logic [N_ICONS-1:0] p2_level;
    logic               active;
    logic [7:0]         pixel_color;
    modport master (output x, y, p1_level, p2_level, input active, pixel_color);
    modport slave  (input x, y, p1_level, p2_level, output active, pixel_color);
endinterface

// File: rtl/hud_icon_flash.sv
// hud_icon_flash: one frame-sampled icon level plus its loss-flash countdown.
module hud_icon_flash #(
    parameter int FLASH_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_fs,
    input  logic i_level,
    output logic o_shadow,
    output logic o_flash
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    logic          r_shadow;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 1'b0;
            r_cnt    <= '0;
        end else if (i_fs) begin
            r_shadow <= i_level;
            r_cnt    <= i_level ? '0 : r_shadow ? CW'(FLASH_FRAMES) : (r_cnt != '0) ? r_cnt - 1'b1 : '0;
        end
    end
    assign o_shadow = r_shadow;
    assign o_flash  = r_cnt != '0;
endmodule

// File: rtl/hud_bar_renderer.sv
// hud_bar_renderer: two mirrored rows of level icons, frame-synchronous sampling, blink on loss.
module hud_bar_renderer
    import hud_pkg::*;
#(
    parameter int         N_ICONS      = 3,
    parameter int         ICON_W       = 40,
    parameter int         ICON_H       = 40,
    parameter int         ICON_GAP     = 20,
    parameter int         BAR_Y        = 410,
    parameter int         P1_X0        = 100,
    parameter int         P2_X0        = 380,
    parameter int         FLASH_FRAMES = 30,
    parameter int         BLINK_HALF   = 4,
    parameter logic [7:0] FULL_COLOR   = HUD_RED,
    parameter logic [7:0] EMPTY_COLOR  = HUD_BLACK,
    parameter logic [7:0] FLASH_COLOR  = HUD_WHITE
) (
    input logic              clk,
    input logic              rst_n,
    hud_bar_renderer_if.slave bus
);
    localparam int IW    = N_ICONS > 1 ? $clog2(N_ICONS) : 1;
    localparam int PITCH = ICON_W + ICON_GAP;
    localparam int BW    = $clog2(BLINK_HALF + 1);
    logic               w_fs;
    logic [10:0]        w_x;
    logic [10:0]        w_y;
    logic               w_hit;
    player_e            w_pl;
    logic [IW-1:0]      w_idx;
    logic               r_hit;
    player_e            r_pl;
    logic [IW-1:0]      r_idx;
    logic [N_ICONS-1:0] w_sh1;
    logic [N_ICONS-1:0] w_sh2;
    logic [N_ICONS-1:0] w_fl1;
    logic [N_ICONS-1:0] w_fl2;
    logic               w_sh;
    logic               w_fl;
    logic [BW-1:0]      r_bcnt;
    logic               r_phase;
    assign w_fs = (bus.x == 10'd0) && (bus.y == 10'd0);
    assign w_x  = {1'b0, bus.x};
    assign w_y  = {1'b0, bus.y};
    // Scan from the highest index down, player 1 last, so the lowest P1 icon wins overlaps.
    always_comb begin
        w_hit = 1'b0;
        w_pl  = P1;
        w_idx = '0;
        if (w_y >= 11'(BAR_Y) && w_y < 11'(BAR_Y + ICON_H)) begin
            for (int i = N_ICONS - 1; i >= 0; i--) begin
                if (w_x >= 11'(P2_X0 + (N_ICONS - 1 - i) * PITCH) && w_x < 11'(P2_X0 + (N_ICONS - 1 - i) * PITCH + ICON_W)) begin
                    w_hit = 1'b1;
                    w_pl  = P2;
                    w_idx = IW'(i);
                end
            end
            for (int i = N_ICONS - 1; i >= 0; i--) begin
                if (w_x >= 11'(P1_X0 + i * PITCH) && w_x < 11'(P1_X0 + i * PITCH + ICON_W)) begin
                    w_hit = 1'b1;
                    w_pl  = P1;
                    w_idx = IW'(i);
                end
            end
        end
    end
    for (genvar i = 0; i < N_ICONS; i++) begin : g_icon
        hud_icon_flash #(.FLASH_FRAMES(FLASH_FRAMES)) u_p1 (
            .clk(clk), .rst_n(rst_n), .i_fs(w_fs), .i_level(bus.p1_level[i]),
            .o_shadow(w_sh1[i]), .o_flash(w_fl1[i])
        );
        hud_icon_flash #(.FLASH_FRAMES(FLASH_FRAMES)) u_p2 (
            .clk(clk), .rst_n(rst_n), .i_fs(w_fs), .i_level(bus.p2_level[i]),
            .o_shadow(w_sh2[i]), .o_flash(w_fl2[i])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_fs) begin
            r_bcnt  <= (r_bcnt == BW'(BLINK_HALF - 1)) ? '0 : r_bcnt + 1'b1;
            r_phase <= (r_bcnt == BW'(BLINK_HALF - 1)) ? ~r_phase : r_phase;
        end
    end
    assign w_sh = (r_pl == P2) ? w_sh2[r_idx] : w_sh1[r_idx];
    assign w_fl = (r_pl == P2) ? w_fl2[r_idx] : w_fl1[r_idx];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit           <= 1'b0;
            r_pl            <= P1;
            r_idx           <= '0;
            bus.active      <= 1'b0;
            bus.pixel_color <= '0;
        end else begin
            r_hit           <= w_hit;
            r_pl            <= w_pl;
            r_idx           <= w_idx;
            bus.active      <= r_hit;
            bus.pixel_color <= !r_hit ? '0 : w_sh ? FULL_COLOR : (w_fl && r_phase) ? FLASH_COLOR : EMPTY_COLOR;
        end
    end
endmodule

// File: tb/tb_hud_bar_renderer.sv
// tb_hud_bar_renderer: table vectors, directed flash sequences and random frames against a frame-level model.
module tb_hud_bar_renderer;
    localparam int N = 3, W = 40, H = 40, G = 20, BY = 410, X1 = 100, X2 = 380, FF = 30, BH = 4;
    localparam int C_FULL = 'hE0, C_EMPTY = 'h00, C_FLASH = 'hFF;
    typedef struct {int x; int y; int exp;} vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int m_fn;
    bit m_sh[2][N];
    int m_loss[2][N];
    vec_t tbl[14];
    hud_bar_renderer_if #(.N_ICONS(N)) bus();
    hud_bar_renderer #(.N_ICONS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask
    // Expected {active,colour} as active*256+colour, from geometry arithmetic and frame history.
    function automatic int model_px(int x, int y);
        int p = -1;
        int i = 0;
        int c;
        if (y < BY || y >= BY + H) return 0;
        if (x >= X1 && (x - X1) % (W + G) < W && (x - X1) / (W + G) < N) begin
            p = 0; i = (x - X1) / (W + G);
        end else if (x >= X2 && (x - X2) % (W + G) < W && (x - X2) / (W + G) < N) begin
            p = 1; i = N - 1 - (x - X2) / (W + G);
        end
        if (p < 0) return 0;
        if (m_sh[p][i]) c = C_FULL;
        else if (m_loss[p][i] >= 0 && m_fn - m_loss[p][i] < FF) c = ((m_fn / BH) % 2 == 1) ? C_FLASH : C_EMPTY;
        else c = C_EMPTY;
        return 256 + c;
    endfunction
    task automatic model_reset();
        m_fn = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                m_sh[p][i] = 1'b0;
                m_loss[p][i] = -1;
            end
    endtask
    task automatic model_frame(logic [N-1:0] l1, logic [N-1:0] l2);
        logic [N-1:0] l;
        m_fn++;
        for (int p = 0; p < 2; p++) begin
            l = (p == 0) ? l1 : l2;
            for (int i = 0; i < N; i++) begin
                if (l[i]) m_loss[p][i] = -1;
                else if (m_sh[p][i]) m_loss[p][i] = m_fn;
                m_sh[p][i] = l[i];
            end
        end
    endtask
    task automatic park();
        bus.x = 10'd799;
        bus.y = 10'd524;
    endtask
    task automatic frame();
        model_frame(bus.p1_level, bus.p2_level);
        bus.x = 10'd0;
        bus.y = 10'd0;
        @(posedge clk); #1;
        park();
    endtask
    task automatic frame_with(logic [N-1:0] l1, logic [N-1:0] l2);
        bus.p1_level = l1;
        bus.p2_level = l2;
        frame();
    endtask
    task automatic pix(int x, int y, output int r);
        bus.x = 10'(x);
        bus.y = 10'(y);
        @(posedge clk); @(posedge clk); #1;
        r = {23'd0, bus.active, bus.pixel_color};
        park();
    endtask
    task automatic chk_pix(string nm, int x, int y, int exp);
        int r;
        pix(x, y, r);
        check(nm, r, exp);
    endtask
    task automatic chk_model(string nm, int x, int y);
        chk_pix(nm, x, y, model_px(x, y));
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        park();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask
    initial begin
        int r;
        int nfl;
        tbl[0]  = '{100, 410, 256 + C_FULL};
        tbl[1]  = '{90, 410, 0};
        tbl[2]  = '{139, 449, 256 + C_FULL};
        tbl[3]  = '{140, 430, 0};
        tbl[4]  = '{160, 420, 256 + C_EMPTY};
        tbl[5]  = '{219, 410, 0};
        tbl[6]  = '{220, 410, 256 + C_FULL};
        tbl[7]  = '{100, 409, 0};
        tbl[8]  = '{100, 450, 0};
        tbl[9]  = '{380, 410, 256 + C_EMPTY};
        tbl[10] = '{440, 449, 256 + C_FULL};
        tbl[11] = '{539, 430, 256 + C_FULL};
        tbl[12] = '{540, 430, 0};
        tbl[13] = '{379, 410, 0};
        bus.p1_level = '0;
        bus.p2_level = '0;
        park();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_out", {23'd0, bus.active, bus.pixel_color}, 0);
        rst_n = 1'b1;
        chk_pix("empty_before_frame", 100, 410, 256 + C_EMPTY);
        frame_with(3'b101, 3'b011);
        foreach (tbl[k]) chk_pix($sformatf("tbl%0d", k), tbl[k].x, tbl[k].y, tbl[k].exp);
        do_reset();
        frame_with(3'b111, 3'b111);
        bus.p1_level = 3'b011;
        chk_pix("no_tear", 220, 410, 256 + C_FULL);
        nfl = 0;
        for (int f = 2; f <= 36; f++) begin
            frame();
            pix(220, 410, r);
            check($sformatf("flash_fn%0d", f), r, model_px(220, 410));
            if (r == 256 + C_FLASH) nfl++;
        end
        check("flash_count", nfl, 16);
        chk_pix("flash_over", 220, 410, 256 + C_EMPTY);
        do_reset();
        frame_with(3'b111, 3'b111);
        bus.p2_level = 3'b011;
        frame(); frame(); frame();
        chk_pix("mirror_380", 380, 410, 256 + C_FLASH);
        chk_pix("mirror_500", 500, 410, 256 + C_FULL);
        chk_pix("mirror_p1", 220, 410, 256 + C_FULL);
        frame_with(3'b111, 3'b111);
        chk_pix("recover_full", 380, 410, 256 + C_FULL);
        bus.p2_level = 3'b011;
        nfl = 0;
        for (int f = 6; f <= 40; f++) begin
            frame();
            pix(380, 410, r);
            check($sformatf("reflash_fn%0d", f), r, model_px(380, 410));
            if (r == 256 + C_FLASH) nfl++;
        end
        check("reflash_count", nfl, 14);
        do_reset();
        frame_with(3'b111, 3'b111);
        frame_with(3'b110, 3'b111);
        chk_pix("fs_capture_i0", 100, 410, 256 + C_EMPTY);
        chk_pix("fs_capture_i1", 160, 410, 256 + C_FULL);
        do_reset();
        frame_with(3'b111, 3'b111);
        bus.p1_level = 3'b011;
        frame(); frame(); frame();
        bus.x = 10'd220;
        bus.y = 10'd410;
        @(posedge clk); @(posedge clk); #1;
        check("pre_async_rst", {23'd0, bus.active, bus.pixel_color}, 256 + C_FLASH);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {23'd0, bus.active, bus.pixel_color}, 0);
        model_reset();
        park();
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame_with(3'b011, 3'b111);
        chk_pix("post_rst_full", 100, 410, 256 + C_FULL);
        frame(); frame(); frame();
        chk_pix("post_rst_noflash", 220, 410, 256 + C_EMPTY);
        do_reset();
        for (int f = 0; f < 120; f++) begin
            if ($urandom_range(0, 3) == 0) frame_with(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            else frame();
            for (int k = 0; k < 3; k++) chk_model("rand", $urandom_range(90, 550), $urandom_range(400, 460));
            if ($urandom_range(0, 1) == 1) bus.p1_level = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) bus.p2_level = 3'($urandom_range(0, 7));
            chk_model("rand_mid", $urandom_range(90, 550), $urandom_range(400, 460));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
